// File: rtl/stack_engine.sv
// stack_engine: hardware stack controller. Owns the stack pointer and turns
// push/pop requests of 1..MAX_BEATS bytes into sequential byte-wide memory
// accesses on a full-descending stack.
// Optional feature macro: STACK_GUARD_EN enables overflow/underflow checking
// and the sticky error flags; without it sp wraps modulo 2^SP_W.
module stack_engine #(
    parameter int DATA_W    = 8,
    parameter int SP_W      = 16,
    parameter int ADDR_W    = 24,
    parameter int MAX_BEATS = 4,
    parameter logic [ADDR_W-SP_W-1:0] STACK_BANK  = '1,
    parameter logic [SP_W-1:0]        STACK_TOP   = 16'hFFFF,
    parameter logic [SP_W-1:0]        STACK_LIMIT = 16'hF000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_pop,
    input  logic [$clog2(MAX_BEATS+1)-1:0]  req_beats,
    input  logic [DATA_W*MAX_BEATS-1:0]     push_data,
    output logic                            resp_valid,
    output logic                            resp_err,
    output logic [DATA_W*MAX_BEATS-1:0]     pop_data,
    input  logic                            sp_load,
    input  logic [SP_W-1:0]                 sp_in,
    output logic [SP_W-1:0]                 sp,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic                            mem_wr_en,
    output logic                            mem_rd_en,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic [DATA_W-1:0]               mem_rdata,
    output logic                            err_overflow,
    output logic                            err_underflow,
    input  logic                            err_clr
);

    localparam int BW    = $clog2(MAX_BEATS + 1);
    localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PUSH     = 2'd1;
    localparam logic [1:0] S_POP      = 2'd2;
    localparam logic [1:0] S_POP_WAIT = 2'd3;

    logic [1:0]                 state_reg;
    logic [SP_W-1:0]            sp_reg;
    logic [BW-1:0]              n_reg;
    logic [BW-1:0]              cnt_reg;
    logic [DATA_W*MAX_BEATS-1:0] data_reg;
    logic [DATA_W-1:0]          pop_beats_reg [MAX_BEATS];
    logic                       rej_reg;

    logic [DATA_W-1:0]          push_beats [MAX_BEATS];
    logic                       accept;
    logic                       beats_bad;
    logic                       set_ovf;
    logic                       set_udf;
    logic                       reject;
    logic                       last_beat;
    logic [BW-1:0]              cap_idx;
    logic [SP_W-1:0]            n_sp;

    // Split latched push payload into beats and assemble pop result; during
    // POP_WAIT the final beat (always beat 0) is passed straight from memory.
    generate
        for (genvar gi = 0; gi < MAX_BEATS; gi++) begin : g_beat
            assign push_beats[gi] = data_reg[gi*DATA_W +: DATA_W];
            if (gi == 0) begin : g_b0
                assign pop_data[gi*DATA_W +: DATA_W] =
                    (state_reg == S_POP_WAIT) ? mem_rdata : pop_beats_reg[gi];
            end else begin : g_bn
                assign pop_data[gi*DATA_W +: DATA_W] = pop_beats_reg[gi];
            end
        end
    endgenerate

    assign accept    = (state_reg == S_IDLE) && !sp_load && req_valid;
    assign beats_bad = (req_beats == '0) || (req_beats > BW'(MAX_BEATS));
    assign last_beat = (cnt_reg == n_reg - BW'(1));
    assign cap_idx   = n_reg - cnt_reg;
    assign n_sp      = SP_W'(n_reg);

`ifdef STACK_GUARD_EN
    logic [SP_W:0] sp_dec;
    logic [SP_W:0] sp_inc;
    logic          ovf_reg;
    logic          udf_reg;

    // Bounds are evaluated one bit wider than sp so wrap-around is visible.
    assign sp_dec  = {1'b0, sp_reg} - (SP_W+1)'(req_beats);
    assign sp_inc  = {1'b0, sp_reg} + (SP_W+1)'(req_beats);
    assign set_ovf = !beats_bad && !req_pop && ($signed(sp_dec) < $signed({1'b0, STACK_LIMIT}));
    assign set_udf = !beats_bad && req_pop && (sp_inc > {1'b0, STACK_TOP});

    // Sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else if (state_reg == S_IDLE) begin
            if (err_clr) begin
                ovf_reg <= 1'b0;
                udf_reg <= 1'b0;
            end
            if (accept && set_ovf) ovf_reg <= 1'b1;
            if (accept && set_udf) udf_reg <= 1'b1;
        end
    end

    assign err_overflow  = ovf_reg;
    assign err_underflow = udf_reg;
`else
    logic unused_err_clr;

    assign set_ovf        = 1'b0;
    assign set_udf        = 1'b0;
    assign err_overflow   = 1'b0;
    assign err_underflow  = 1'b0;
    assign unused_err_clr = err_clr;
`endif

    assign reject = beats_bad || set_ovf || set_udf;

    // Main controller: request acceptance, beat sequencing and sp update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            sp_reg    <= STACK_TOP;
            n_reg     <= '0;
            cnt_reg   <= '0;
            data_reg  <= '0;
            rej_reg   <= 1'b0;
            for (int k = 0; k < MAX_BEATS; k++) pop_beats_reg[k] <= '0;
        end else begin
            rej_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (sp_load) begin
                        sp_reg <= sp_in;
                    end else if (req_valid) begin
                        if (reject) begin
                            rej_reg <= 1'b1;
                        end else begin
                            n_reg     <= req_beats;
                            cnt_reg   <= '0;
                            data_reg  <= push_data;
                            for (int k = 0; k < MAX_BEATS; k++) pop_beats_reg[k] <= '0;
                            state_reg <= req_pop ? S_POP : S_PUSH;
                        end
                    end
                end
                S_PUSH: begin
                    cnt_reg <= cnt_reg + BW'(1);
                    if (last_beat) begin
                        sp_reg    <= sp_reg - n_sp;
                        state_reg <= S_IDLE;
                    end
                end
                S_POP: begin
                    // Data for read cnt-1 arrives now; byte at sp+j is beat n-1-j.
                    if (cnt_reg != '0) begin
                        for (int k = 0; k < MAX_BEATS; k++) begin
                            if (cap_idx == BW'(k)) pop_beats_reg[k] <= mem_rdata;
                        end
                    end
                    cnt_reg <= cnt_reg + BW'(1);
                    if (last_beat) state_reg <= S_POP_WAIT;
                end
                S_POP_WAIT: begin
                    pop_beats_reg[0] <= mem_rdata;
                    sp_reg           <= sp_reg + n_sp;
                    state_reg        <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Handshake, response and memory port outputs decoded from state.
    always_comb begin
        req_ready  = (state_reg == S_IDLE) && !sp_load;
        resp_valid = rej_reg || ((state_reg == S_PUSH) && last_beat) || (state_reg == S_POP_WAIT);
        resp_err   = rej_reg;
        mem_wr_en  = (state_reg == S_PUSH);
        mem_rd_en  = (state_reg == S_POP);
        mem_wdata  = '0;
        mem_addr   = {STACK_BANK, sp_reg};
        if (state_reg == S_PUSH) begin
            mem_addr  = {STACK_BANK, sp_reg - SP_W'(1) - SP_W'(cnt_reg)};
            mem_wdata = push_beats[cnt_reg[IDX_W-1:0]];
        end else if (state_reg == S_POP) begin
            mem_addr  = {STACK_BANK, sp_reg + SP_W'(cnt_reg)};
        end
    end

    assign sp = sp_reg;

endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: directed, table-driven check of stack_engine with a
// byte-wide memory model on the stack bank; guard-dependent expectations
// follow STACK_GUARD_EN.
module tb_stack_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_pop = 1'b0;
    logic [2:0]  req_beats = '0;
    logic [31:0] push_data = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] pop_data;
    logic        sp_load = 1'b0;
    logic [15:0] sp_in = '0;
    logic [15:0] sp;
    logic [23:0] mem_addr;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        err_overflow;
    logic        err_underflow;
    logic        err_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:65535];

    stack_engine dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_pop(req_pop),
        .req_beats(req_beats), .push_data(push_data),
        .resp_valid(resp_valid), .resp_err(resp_err), .pop_data(pop_data),
        .sp_load(sp_load), .sp_in(sp_in), .sp(sp),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .err_overflow(err_overflow), .err_underflow(err_underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr[15:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[15:0]];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // One request: drive, wait for the response, compare latency, strobes,
    // data and the resulting sp. Prints one line per transaction.
    task automatic run_req(input string tag, input logic pop, input logic [2:0] beats,
                           input logic [31:0] data, input logic exp_err, input int exp_cycle,
                           input int exp_strobes, input logic [15:0] exp_first,
                           input logic chk_data, input logic [31:0] exp_pop,
                           input logic [15:0] exp_sp);
        int          c;
        int          strobes;
        int          bad;
        int          got_cycle;
        logic        done;
        logic        got_err;
        logic [23:0] first;
        logic [31:0] got_pop;
        @(negedge clk);
        req_valid = 1'b1;
        req_pop   = pop;
        req_beats = beats;
        push_data = data;
        #1 chk({tag, " ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        c = 0; done = 1'b0; strobes = 0; bad = 0; got_cycle = 0;
        got_err = 1'b0; first = '0; got_pop = '0;
        while (!done && c < 16) begin
            @(negedge clk);
            c++;
            if (c == 1) req_valid = 1'b0;
            if (pop ? mem_wr_en : mem_rd_en) bad++;
            if (pop ? mem_rd_en : mem_wr_en) begin
                if (strobes == 0) first = mem_addr;
                strobes++;
            end
            if (resp_valid) begin
                done = 1'b1;
                got_cycle = c;
                got_err = resp_err;
                got_pop = pop_data;
            end
        end
        chk({tag, " resp_seen"}, 32'(done), 32'd1);
        chk({tag, " resp_cycle"}, 32'(got_cycle), 32'(exp_cycle));
        chk({tag, " resp_err"}, 32'(got_err), 32'(exp_err));
        chk({tag, " strobes"}, 32'(strobes), 32'(exp_strobes));
        chk({tag, " wrong_strobes"}, 32'(bad), 32'd0);
        if (exp_strobes > 0) chk({tag, " first_addr"}, 32'(first), 32'({8'hFF, exp_first}));
        if (chk_data) chk({tag, " pop_data"}, got_pop, exp_pop);
        @(negedge clk);
        chk({tag, " sp"}, 32'(sp), 32'(exp_sp));
        $display("txn %s pop=%0d n=%0d data=%h -> cycle=%0d err=%0d strobes=%0d pop_data=%h sp=%h",
                 tag, pop, beats, data, got_cycle, got_err, strobes, got_pop, sp);
    endtask

    task automatic load_sp(input logic [15:0] v);
        @(negedge clk);
        sp_load = 1'b1;
        sp_in   = v;
        @(negedge clk);
        sp_load = 1'b0;
        chk("sp_load", 32'(sp), 32'(v));
        $display("txn sp_load %h -> sp=%h", v, sp);
    endtask

    typedef struct {
        logic        pop;
        logic [2:0]  beats;
        logic [31:0] data;
        logic        exp_err;
        int          exp_cycle;
        int          exp_strobes;
        logic [15:0] exp_first;
        logic [31:0] exp_pop;
        logic [15:0] exp_sp;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{1'b0, 3'd2, 32'h0000BEEF, 1'b0, 2, 2, 16'hFFFE, 32'h0,        16'hFFFD};
        vecs[1]  = '{1'b1, 3'd2, 32'hDEADDEAD, 1'b0, 3, 2, 16'hFFFD, 32'h0000BEEF, 16'hFFFF};
        vecs[2]  = '{1'b0, 3'd4, 32'h12345678, 1'b0, 4, 4, 16'hFFFE, 32'h0,        16'hFFFB};
        vecs[3]  = '{1'b0, 3'd1, 32'h000000A5, 1'b0, 1, 1, 16'hFFFA, 32'h0,        16'hFFFA};
        vecs[4]  = '{1'b1, 3'd1, 32'h0,        1'b0, 2, 1, 16'hFFFA, 32'h000000A5, 16'hFFFB};
        vecs[5]  = '{1'b1, 3'd3, 32'h0,        1'b0, 4, 3, 16'hFFFB, 32'h00123456, 16'hFFFE};
        vecs[6]  = '{1'b1, 3'd1, 32'h0,        1'b0, 2, 1, 16'hFFFE, 32'h00000078, 16'hFFFF};
        vecs[7]  = '{1'b0, 3'd0, 32'h11111111, 1'b1, 1, 0, 16'h0000, 32'h0,        16'hFFFF};
        vecs[8]  = '{1'b1, 3'd5, 32'h0,        1'b1, 1, 0, 16'h0000, 32'h0,        16'hFFFF};
        vecs[9]  = '{1'b0, 3'd3, 32'h00C0FFEE, 1'b0, 3, 3, 16'hFFFE, 32'h0,        16'hFFFC};
        vecs[10] = '{1'b1, 3'd3, 32'h0,        1'b0, 4, 3, 16'hFFFC, 32'h00C0FFEE, 16'hFFFF};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_err", 32'(resp_err), 32'd0);
        chk("rst pop_data", pop_data, 32'd0);
        chk("rst strobes", 32'({mem_wr_en, mem_rd_en}), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'h00FFFFFF);
        chk("rst sp", 32'(sp), 32'h0000FFFF);
        chk("rst flags", 32'({err_overflow, err_underflow}), 32'd0);

        // Table-driven transactions (no bounds hit in either build).
        for (int i = 0; i < 11; i++) begin
            run_req($sformatf("v%0d", i), vecs[i].pop, vecs[i].beats, vecs[i].data,
                    vecs[i].exp_err, vecs[i].exp_cycle, vecs[i].exp_strobes,
                    vecs[i].exp_first, vecs[i].pop && !vecs[i].exp_err,
                    vecs[i].exp_pop, vecs[i].exp_sp);
            chk($sformatf("v%0d flags", i), 32'({err_overflow, err_underflow}), 32'd0);
        end

        // Overflow near the limit.
        load_sp(16'hF001);
`ifdef STACK_GUARD_EN
        run_req("ovf", 1'b0, 3'd2, 32'h00001122, 1'b1, 1, 0, 16'h0, 1'b0, 32'h0, 16'hF001);
        chk("ovf err_overflow", 32'(err_overflow), 32'd1);
        chk("ovf err_underflow", 32'(err_underflow), 32'd0);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("ovf cleared", 32'(err_overflow), 32'd0);
`else
        run_req("ovf", 1'b0, 3'd2, 32'h00001122, 1'b0, 2, 2, 16'hF000, 1'b0, 32'h0, 16'hEFFF);
        chk("ovf err_overflow", 32'(err_overflow), 32'd0);
`endif

        // Underflow from the empty stack.
        load_sp(16'hFFFF);
`ifdef STACK_GUARD_EN
        run_req("udf", 1'b1, 3'd1, 32'h0, 1'b1, 1, 0, 16'h0, 1'b0, 32'h0, 16'hFFFF);
        chk("udf err_underflow", 32'(err_underflow), 32'd1);
        chk("udf err_overflow", 32'(err_overflow), 32'd0);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("udf cleared", 32'(err_underflow), 32'd0);
`else
        run_req("udf", 1'b1, 3'd1, 32'h0, 1'b0, 2, 1, 16'hFFFF, 1'b0, 32'h0, 16'h0000);
        chk("udf err_underflow", 32'(err_underflow), 32'd0);
`endif

        // Asynchronous reset in the middle of a 4-beat push.
        load_sp(16'hFFF8);
        @(negedge clk);
        req_valid = 1'b1; req_pop = 1'b0; req_beats = 3'd4; push_data = 32'hA1B2C3D4;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("midrst wr_before", 32'(mem_wr_en), 32'd1);
        chk("midrst addr_before", 32'(mem_addr), 32'h00FFFFF6);
        rst = 1'b0;
        #1;
        chk("midrst wr_dropped", 32'(mem_wr_en), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst sp", 32'(sp), 32'h0000FFFF);
        chk("midrst req_ready", 32'(req_ready), 32'd1);
        $display("txn midreset push n=4 -> sp=%h req_ready=%0d", sp, req_ready);

        // sp_load and request in the same idle cycle.
        @(negedge clk);
        sp_load = 1'b1; sp_in = 16'hFFF0;
        req_valid = 1'b1; req_pop = 1'b0; req_beats = 3'd1; push_data = 32'h0000005A;
        #1 chk("ldreq ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        sp_load = 1'b0;
        #1;
        chk("ldreq sp", 32'(sp), 32'h0000FFF0);
        chk("ldreq not_accepted", 32'(mem_wr_en), 32'd0);
        chk("ldreq ready_high", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("ldreq wr", 32'(mem_wr_en), 32'd1);
        chk("ldreq addr", 32'(mem_addr), 32'h00FFFFEF);
        chk("ldreq wdata", 32'(mem_wdata), 32'h0000005A);
        chk("ldreq resp", 32'(resp_valid), 32'd1);
        @(negedge clk);
        chk("ldreq sp_after", 32'(sp), 32'h0000FFEF);
        $display("txn sp_load+push n=1 -> sp=%h", sp);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_engine.md
# stack_engine

Parametrised hardware stack controller for the RISC cores: owns the stack pointer and turns single push/pop requests of 1..MAX_BEATS bytes into sequential byte-wide memory accesses.

- Replaces the fixed 16-bit, single-access stack logic in the datapath.
- Adds multi-beat transfers (e.g. a 16-bit PC or a 24-bit address in one request), a ready/valid request handshake, bounds checking, and stack-pointer load for context switch.
- Sits between core control and the data-memory port arbiter.

## Interface
Parameters:
- DATA_W, 8: memory data width, one beat
- SP_W, 16: stack pointer width
- ADDR_W, 24: memory address width; must be greater than SP_W
- MAX_BEATS, 4: maximum beats per request
- STACK_BANK, all ones: upper ADDR_W-SP_W address bits
- STACK_TOP, 16'hFFFF: reset value of sp, the empty-stack position
- STACK_LIMIT, 16'hF000: lowest address the stack may occupy

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  engine can accept a request
- req_pop  in  1  0 = push, 1 = pop
- req_beats  in  $clog2(MAX_BEATS+1)  beat count n, 1..MAX_BEATS
- push_data  in  DATA_W*MAX_BEATS  push payload; beat k is bits [k*DATA_W +: DATA_W]
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid; request rejected
- pop_data  out  DATA_W*MAX_BEATS  pop result; valid with resp_valid; unused beats are 0
- sp_load  in  1  load sp from sp_in
- sp_in  in  SP_W  new sp value
- sp  out  SP_W  current stack pointer
- mem_addr  out  ADDR_W  equal to {STACK_BANK, access pointer}
- mem_wr_en, mem_rd_en  out  1  memory strobes
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, one-cycle latency
- err_overflow, err_underflow  out  1  sticky error flags
- err_clr  in  1  clears both sticky flags

## Operation
Stack model:
- Full-descending: sp points to the last byte written.
- Push of n beats writes beat k at sp-1-k, for k = 0..n-1. Beat 0 (LS) is written first, at the highest address. Afterwards sp -= n.
- Pop of n beats reads addresses sp, sp+1, ..., sp+n-1. Byte at sp+j becomes beat n-1-j, so the MS byte comes out first. Afterwards sp += n.
- A push followed by a pop of the same n returns identical data.

States: IDLE, PUSH, POP, POP_WAIT.
- IDLE: req_ready = !sp_load.
  - sp_load has priority over a request: sp <= sp_in, and no request is accepted that cycle.
  - On acceptance, n, the op and push_data are latched, and a beat counter is cleared.
  - A bounds failure goes straight to a resp_valid pulse with resp_err = 1 (state stays IDLE).
  - Otherwise the engine moves to PUSH or POP.
- PUSH: one write per cycle. On the last beat it asserts resp_valid, updates sp, and returns to IDLE.
- POP: one read per cycle. Data is captured one cycle after each read strobe. After the last read the engine goes to POP_WAIT.
- POP_WAIT: captures the final beat, asserts resp_valid with pop_data, updates sp, and returns to IDLE.
- Outside IDLE, sp_load and err_clr are ignored. req_ready is 0.

Bounds rules:
- Arithmetic is done at SP_W+1 bits.
- Overflow: push with sp - n < STACK_LIMIT, evaluated on the signed SP_W+1-bit result.
- Underflow: pop with sp + n > STACK_TOP.
- A rejected request makes no memory access and does not change sp. It sets the matching sticky flag.
- req_beats of 0, or greater than MAX_BEATS, is rejected with resp_err = 1. No flag is set.
- err_clr in the same cycle as a new error: the set wins.

## Timing
Reset values:
- State IDLE, sp = STACK_TOP.
- req_ready = 1, resp_valid = 0, resp_err = 0, pop_data = 0.
- All memory strobes 0, mem_addr = {STACK_BANK, STACK_TOP}.
- Both error flags 0.

Reset is asynchronous: strobes drop immediately, even mid-transfer. A partial push leaves the memory contents undefined and sp = STACK_TOP.

Latency, counted from the acceptance edge (cycle 0):
- Push: strobes in cycles 1..n; resp_valid in cycle n. Next acceptance is possible at the end of cycle n+1.
- Pop: read strobes in cycles 1..n; resp_valid in cycle n+1.
- Rejected request: resp_valid and resp_err in cycle 1.

Update timing:
- sp updates on the edge that ends the resp_valid cycle.
- The sp output is registered.

## Configuration
Macro STACK_GUARD_EN.
- Defined: bounds checking as described above.
- Undefined:
  - No overflow/underflow checks; sp wraps modulo 2^SP_W.
  - err_overflow and err_underflow are tied to 0.
  - resp_err is asserted only for an illegal req_beats value.

## Test plan
- Reset, then push n=2 with push_data=16'hBEEF. Required: writes EF@FFFFFE then BE@FFFFFD; resp_valid in cycle 2; sp=FFFD.
- Pop n=2 straight after the push above. Required: reads at FFFD, FFFE; pop_data=16'hBEEF in cycle 3; sp=FFFF.
- sp_load to F001, then push n=2. Required: resp_err=1 in cycle 1; err_overflow=1; no strobes; sp stays F001. Then err_clr clears the flag.
- From reset, pop n=1. Required: err_underflow=1; resp_err=1; sp=FFFF.
- Assert rst mid-way through a push n=4. Required: strobes drop the same cycle; after release, sp=FFFF and req_ready=1.
- sp_load and req_valid asserted in the same IDLE cycle. Required: sp=sp_in; request not accepted (req_ready=0); accepted the next cycle.
